awb_gain: RTL and testbench

- Gray-world auto-white-balance stage directly downstream of the per-colour mean accumulator.
- On the end-of-frame pulse it captures the R/G/B means and computes red and blue gains relative to green with a serial restoring divider.
- It applies the committed gains to a pixel stream, producing white-balanced 8-bit values with saturation.

---
 rtl/awb_gain.sv | 174 +++++++++++++++++
 tb/tb_awb_gain.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/awb_gain.sv
// Gray-world auto-white-balance: computes R/B gains relative to G with a serial
// restoring divider and applies them to a pixel stream. Optional macro: AWB_SAT_CNT_EN.
module awb_gain #(
  parameter int FRAC = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       last_i,
  input  logic [7:0] r_mean_i,
  input  logic [7:0] g_mean_i,
  input  logic [7:0] b_mean_i,
  input  logic       pix_valid_i,
  input  logic [1:0] pix_color_i,
  input  logic [7:0] pix_value_i,
  output logic       pix_valid_o,
  output logic [1:0] pix_color_o,
  output logic [7:0] pix_value_o,
  output logic [7:0] gain_r_o,
  output logic [7:0] gain_b_o,
  output logic       busy_o,
  output logic       done_o
`ifdef AWB_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt_o
`endif
);

  localparam int N = 8 + FRAC;
  localparam int CW = $clog2(N);
  localparam logic [7:0] UNITY = 8'(1 << FRAC);

  typedef enum logic [2:0] {IDLE, CAPTURE, DIV_R, DIV_B, COMMIT} state_t;

  state_t state;
  logic [7:0] r_lat, g_lat, b_lat;
  logic [N-1:0] dvd;
  logic [N-1:0] q;
  logic [8:0] rem;
  logic [CW-1:0] cnt;
  logic [7:0] gain_r_pend, gain_b_pend;

  // One restoring step per cycle on whichever divisor the current state uses
  logic [7:0] divisor;
  logic [8:0] rem_sh, rem_sub, rem_n;
  logic       ge;
  logic [N-1:0] q_n, dvd_n;
  logic [7:0] quot;

  always_comb begin
    divisor = (state == DIV_B) ? b_lat : r_lat;
    rem_sh  = {rem[7:0], dvd[N-1]};
    rem_sub = rem_sh - {1'b0, divisor};
    ge      = (rem_sh >= {1'b0, divisor});
    rem_n   = ge ? rem_sub : rem_sh;
    q_n     = {q[N-2:0], ge};
    dvd_n   = {dvd[N-2:0], 1'b0};
    if (divisor == 8'd0) quot = 8'hFF;
    else if (|q_n[N-1:8]) quot = 8'hFF;
    else quot = q_n[7:0];
  end

  // The remainder never exceeds the divisor, so its top bit and the
  // quotient bit shifted out are always zero.
  logic unused_div;
  assign unused_div = rem[8] ^ q[N-1];

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_lat       <= '0;
      g_lat       <= '0;
      b_lat       <= '0;
      dvd         <= '0;
      q           <= '0;
      rem         <= '0;
      cnt         <= '0;
      gain_r_pend <= UNITY;
      gain_b_pend <= UNITY;
      gain_r_o    <= UNITY;
      gain_b_o    <= UNITY;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (last_i) state <= CAPTURE;
        CAPTURE: begin
          r_lat <= r_mean_i;
          g_lat <= g_mean_i;
          b_lat <= b_mean_i;
          dvd   <= {g_mean_i, {FRAC{1'b0}}};
          q     <= '0;
          rem   <= '0;
          cnt   <= '0;
          state <= DIV_R;
        end
        DIV_R, DIV_B: begin
          rem <= rem_n;
          q   <= q_n;
          dvd <= dvd_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            rem <= '0;
            q   <= '0;
            cnt <= '0;
            dvd <= {g_lat, {FRAC{1'b0}}};
            if (state == DIV_R) begin
              gain_r_pend <= quot;
              state       <= DIV_B;
            end else begin
              gain_b_pend <= quot;
              state       <= COMMIT;
            end
          end
        end
        COMMIT: begin
          gain_r_o <= gain_r_pend;
          gain_b_o <= gain_b_pend;
          done_o   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel path: the gain is frozen per pixel in stage 1
  logic       v1;
  logic [1:0] c1;
  logic [7:0] x1, g1, sel_gain;
  logic [15:0] prod, res;
  logic       clip;

  always_comb begin
    case (pix_color_i)
      2'd0:    sel_gain = gain_r_o;
      2'd2:    sel_gain = gain_b_o;
      default: sel_gain = UNITY;
    endcase
    prod = {8'd0, x1} * {8'd0, g1};
    res  = prod >> FRAC;
    clip = |res[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      c1          <= '0;
      x1          <= '0;
      g1          <= UNITY;
      pix_valid_o <= 1'b0;
      pix_color_o <= '0;
      pix_value_o <= '0;
    end else begin
      v1          <= pix_valid_i;
      c1          <= pix_color_i;
      x1          <= pix_value_i;
      g1          <= sel_gain;
      pix_valid_o <= v1;
      pix_color_o <= c1;
      pix_value_o <= clip ? 8'hFF : res[7:0];
    end
  end

`ifdef AWB_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_o <= '0;
    else if (done_o) sat_cnt_o <= '0;
    else if (v1 && clip && sat_cnt_o != 16'hFFFF) sat_cnt_o <= sat_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_awb_gain.sv
// Directed bench for awb_gain: pixel scoreboard with latency tagging plus
// directed gain/latency/abort checks.
module tb_awb_gain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       last_i;
  logic [7:0] r_mean_i, g_mean_i, b_mean_i;
  logic       pix_valid_i;
  logic [1:0] pix_color_i;
  logic [7:0] pix_value_i;
  logic       pix_valid_o;
  logic [1:0] pix_color_o;
  logic [7:0] pix_value_o;
  logic [7:0] gain_r_o, gain_b_o;
  logic       busy_o, done_o;
`ifdef AWB_SAT_CNT_EN
  logic [15:0] sat_cnt_o;
`endif

  always #5 clk = ~clk;

  awb_gain dut (
    .clk(clk), .rst_n(rst_n), .last_i(last_i),
    .r_mean_i(r_mean_i), .g_mean_i(g_mean_i), .b_mean_i(b_mean_i),
    .pix_valid_i(pix_valid_i), .pix_color_i(pix_color_i), .pix_value_i(pix_value_i),
    .pix_valid_o(pix_valid_o), .pix_color_o(pix_color_o), .pix_value_o(pix_value_o),
    .gain_r_o(gain_r_o), .gain_b_o(gain_b_o), .busy_o(busy_o), .done_o(done_o)
`ifdef AWB_SAT_CNT_EN
    , .sat_cnt_o(sat_cnt_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  // {expected output cycle, colour, value}
  logic [25:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel
  always @(negedge clk) begin
    logic [25:0] e;
    if (done_o) n_done++;
    if (pix_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pix_latency", cyc, int'(e[25:10]));
        check("pix_color", pix_color_o, e[9:8]);
        check("pix_value", pix_value_o, e[7:0]);
      end
    end
  end

  task automatic send_pix(input logic [1:0] c, input logic [7:0] v, input logic [7:0] e);
    @(posedge clk); #1;
    pix_valid_i = 1'b1;
    pix_color_i = c;
    pix_value_i = v;
    exp_q.push_back({16'(cyc + 2), c, e});
  endtask

  task automatic pix_idle(input int n);
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_calc(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input int exp_gr, input int exp_gb, input bit extra_last);
    int n;
    int d0;
    bit busy_ok;
    @(posedge clk); #1;
    r_mean_i = r; g_mean_i = g; b_mean_i = b;
    last_i = 1'b1;
    @(posedge clk); #1;
    last_i = 1'b0;
    d0 = n_done;
    check("busy_after_last", busy_o, 1);
    n = 0;
    busy_ok = 1'b1;
    while (!done_o && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      last_i = extra_last && (n == 10);
      if (!done_o && !busy_o) busy_ok = 1'b0;
    end
    last_i = 1'b0;
    check("done_latency", n, 30);
    check("busy_throughout", busy_ok, 1);
    check("busy_at_done", busy_o, 0);
    check("gain_r", gain_r_o, exp_gr);
    check("gain_b", gain_b_o, exp_gb);
    @(posedge clk); #1;
    check("done_one_cycle", done_o, 0);
    repeat (40) @(posedge clk);
    #1;
    check("done_count", n_done - d0, 1);
  endtask

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    last_i = 1'b0;
    r_mean_i = '0; g_mean_i = '0; b_mean_i = '0;
    pix_valid_i = 1'b0; pix_color_i = '0; pix_value_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gain_r", gain_r_o, 64);
    check("rst_gain_b", gain_b_o, 64);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pix_valid", pix_valid_o, 0);
    check("rst_pix_value", pix_value_o, 0);
`ifdef AWB_SAT_CNT_EN
    check("rst_sat_cnt", sat_cnt_o, 0);
`endif
    rst_n = 1'b1;

    // Unity gains after reset
    send_pix(2'd0, 8'd100, 8'd100);
    send_pix(2'd1, 8'd50, 8'd50);
    send_pix(2'd2, 8'd200, 8'd200);
    send_pix(2'd3, 8'd9, 8'd9);
    pix_idle(4);
    check("idle_gain_r", gain_r_o, 64);
    check("idle_busy", busy_o, 0);

    // 8192/64 = 128, 8192/32 = 256 -> 255
    run_calc(8'd64, 8'd128, 8'd32, 128, 255, 1'b0);
    send_pix(2'd0, 8'd100, 8'd200);
    send_pix(2'd2, 8'd100, 8'd255);
    send_pix(2'd1, 8'd100, 8'd100);
    send_pix(2'd3, 8'd77, 8'd77);
    send_pix(2'd2, 8'd20, 8'd79);
    pix_idle(4);

    // Zero divisor -> 255; 3200/200 = 16
    run_calc(8'd0, 8'd50, 8'd200, 255, 16, 1'b0);
`ifdef AWB_SAT_CNT_EN
    check("sat_cnt_cleared", sat_cnt_o, 0);
`endif
    send_pix(2'd0, 8'd100, 8'd255);
    send_pix(2'd0, 8'd100, 8'd255);
    send_pix(2'd0, 8'd100, 8'd255);
    send_pix(2'd2, 8'd200, 8'd50);
    send_pix(2'd1, 8'd7, 8'd7);
    send_pix(2'd0, 8'd0, 8'd0);
    pix_idle(4);
`ifdef AWB_SAT_CNT_EN
    check("sat_cnt_three", sat_cnt_o, 3);
`endif

    // Second last_i mid-calculation is ignored
    run_calc(8'd64, 8'd128, 8'd32, 128, 255, 1'b1);
`ifdef AWB_SAT_CNT_EN
    check("sat_cnt_after_done", sat_cnt_o, 0);
`endif

    // Reset during DIV_B abandons the calculation
    @(posedge clk); #1;
    r_mean_i = 8'd0; g_mean_i = 8'd50; b_mean_i = 8'd200;
    last_i = 1'b1;
    @(posedge clk); #1;
    last_i = 1'b0;
    d0 = n_done;
    repeat (20) @(posedge clk);
    #1;
    check("busy_before_abort", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("abort_gain_r", gain_r_o, 64);
    check("abort_gain_b", gain_b_o, 64);
    check("abort_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    check("abort_busy_after", busy_o, 0);
    check("abort_gain_r_after", gain_r_o, 64);

    send_pix(2'd2, 8'd33, 8'd33);
    pix_idle(4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
